// File: rtl/laconic_pkg.sv
// Shared definitions for the Laconic term-encoding datapath.
// Holds the default widths, the encoder state type and the term sign encoding.
package laconic_pkg;

  localparam int DEF_W  = 16;
  localparam int DEF_EW = 5;
  localparam int DEF_CW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam logic TERM_POS = 1'b0;
  localparam logic TERM_NEG = 1'b1;

endpackage

// File: rtl/laconic_term_encoder_lsb_priority_encoder.sv
// Lowest-set-bit priority encoder: index of the least significant 1 plus an any-set flag.
// The index is 0 when no bit is set.
module lsb_priority_encoder #(
  parameter int WIDTH = 17,
  parameter int IDX_W = 5
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/laconic_term_encoder.sv
// Serial non-adjacent-form encoder: one signed power-of-two term per cycle, LSB-first,
// with a one-hot exponent column for the downstream popcount tree.
module laconic_term_encoder
  import laconic_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int EW = DEF_EW,
  parameter int CW = DEF_CW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [W-1:0]  in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          out_sign_o,
  output logic [EW-1:0] out_exp_o,
  output logic [W:0]    out_onehot_o,
  output logic [CW-1:0] out_idx_o,
  output logic          out_last_o,
  output logic          out_zero_o
);

  localparam int RW = W + 2;

  state_e        state_q, state_d;
  logic [RW-1:0] rem_q;
  logic [CW-1:0] idx_q, idx_d;
  logic          load;

  logic          sign_q, last_q, zero_q;
  logic [EW-1:0] exp_q;
  logic [W:0]    onehot_q;

  logic [RW-1:0] src, step, src_next;
  logic [EW-1:0] p;
  logic          any_set, term_neg;
  logic          sign_d, last_d, zero_d;
  logic [EW-1:0] exp_d;
  logic [W:0]    onehot_d;

  // rem_q holds the remainder left after the term currently on the outputs, so the
  // next term is always derived from a single source: the operand or that remainder.
  assign src = (state_q == IDLE) ? RW'(in_data_i) : rem_q;

  lsb_priority_encoder #(
    .WIDTH(W + 1),
    .IDX_W(EW)
  ) u_lsb_pe (
    .vec_i(src[W:0]),
    .idx_o(p),
    .any_o(any_set)
  );

  assign step     = RW'(1) << p;
  assign term_neg = |(src & (step << 1));

  always_comb begin
    src_next = '0;
    if (any_set) begin
      src_next = term_neg ? (src + step) : (src - step);
    end
    sign_d   = (any_set && term_neg) ? TERM_NEG : TERM_POS;
    exp_d    = any_set ? p : '0;
    onehot_d = any_set ? step[W:0] : '0;
    last_d   = (src_next == '0);
    zero_d   = !any_set;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = EMIT;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      EMIT: begin
        if (out_ready_i) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + CW'(1);
            load  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      idx_q    <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      onehot_q <= '0;
      last_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        rem_q    <= src_next;
        sign_q   <= sign_d;
        exp_q    <= exp_d;
        onehot_q <= onehot_d;
        last_q   <= last_d;
        zero_q   <= zero_d;
      end
    end
  end

  assign in_ready_o   = (state_q == IDLE);
  assign out_valid_o  = (state_q == EMIT);
  assign out_sign_o   = sign_q;
  assign out_exp_o    = exp_q;
  assign out_onehot_o = onehot_q;
  assign out_idx_o    = idx_q;
  assign out_last_o   = last_q;
  assign out_zero_o   = zero_q;

endmodule

// File: tb/tb_laconic_term_encoder.sv
// Directed bench for laconic_term_encoder: hand-computed NAF term sequences,
// backpressure hold, back-to-back operands and asynchronous reset mid-stream.
module tb_laconic_term_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [4:0]  out_exp;
  logic [16:0] out_onehot;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        out_zero;

  int checks;
  int failures;
  int sum;

  laconic_term_encoder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_sign_o  (out_sign),
    .out_exp_o   (out_exp),
    .out_onehot_o(out_onehot),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last),
    .out_zero_o  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] data);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
  endtask

  task automatic check_beat(input string tag, input logic sgn, input int ex, input int idx,
                            input logic last, input logic zero);
    logic [16:0] oh;
    oh = zero ? 17'h0 : (17'h1 << ex);
    check({tag, ".valid"},  32'(out_valid),  32'd1);
    check({tag, ".ready"},  32'(in_ready),   32'd0);
    check({tag, ".sign"},   32'(out_sign),   32'(sgn));
    check({tag, ".exp"},    32'(out_exp),    32'(ex));
    check({tag, ".onehot"}, 32'(out_onehot), 32'(oh));
    check({tag, ".idx"},    32'(out_idx),    32'(idx));
    check({tag, ".last"},   32'(out_last),   32'(last));
    check({tag, ".zero"},   32'(out_zero),   32'(zero));
    $display("beat %s: sign=%0d exp=%0d onehot=0x%05h idx=%0d last=%0d zero=%0d",
             tag, out_sign, out_exp, out_onehot, out_idx, out_last, out_zero);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'd0);
    check({tag, ".ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b1;

    // Reset state
    #12;
    check("rst.valid",  32'(out_valid),  32'd0);
    check("rst.ready",  32'(in_ready),   32'd1);
    check("rst.sign",   32'(out_sign),   32'd0);
    check("rst.exp",    32'(out_exp),    32'd0);
    check("rst.onehot", 32'(out_onehot), 32'd0);
    check("rst.idx",    32'(out_idx),    32'd0);
    check("rst.last",   32'(out_last),   32'd0);
    check("rst.zero",   32'(out_zero),   32'd0);
    rst_n = 1'b1;
    tick();

    // Zero operand: single zero beat, then idle
    send(16'h0000);
    check_beat("zero", 1'b0, 0, 0, 1'b1, 1'b1);
    tick();
    check_idle("zero.after");
    tick();

    // 0x0007 = -1 + 8
    send(16'h0007);
    check_beat("x0007.b0", 1'b1, 0, 0, 1'b0, 1'b0);
    tick();
    check_beat("x0007.b1", 1'b0, 3, 1, 1'b1, 1'b0);
    tick();
    check_idle("x0007.after");

    // 0xFFFF = -1 + 65536
    send(16'hFFFF);
    sum = 0;
    check_beat("xFFFF.b0", 1'b1, 0, 0, 1'b0, 1'b0);
    sum += out_sign ? -(1 << out_exp) : (1 << out_exp);
    tick();
    check_beat("xFFFF.b1", 1'b0, 16, 1, 1'b1, 1'b0);
    sum += out_sign ? -(1 << out_exp) : (1 << out_exp);
    check("xFFFF.sum", 32'(sum), 32'd65535);
    tick();
    check_idle("xFFFF.after");

    // 0x5555 then 0xAAAA back-to-back after exactly one idle cycle
    send(16'h5555);
    for (int i = 0; i < 8; i++) begin
      check_beat($sformatf("x5555.b%0d", i), 1'b0, 2 * i, i, (i == 7), 1'b0);
      tick();
    end
    check_idle("x5555.after");
    send(16'hAAAA);
    for (int i = 0; i < 8; i++) begin
      check_beat($sformatf("xAAAA.b%0d", i), 1'b0, 2 * i + 1, i, (i == 7), 1'b0);
      tick();
    end
    check_idle("xAAAA.after");
    tick();

    // Backpressure: beat 0 held for three stalled cycles
    out_ready = 1'b0;
    send(16'h0007);
    for (int i = 0; i < 3; i++) begin
      check_beat($sformatf("bp.stall%0d", i), 1'b1, 0, 0, 1'b0, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    check_beat("bp.b0", 1'b1, 0, 0, 1'b0, 1'b0);
    tick();
    check_beat("bp.b1", 1'b0, 3, 1, 1'b1, 1'b0);
    tick();
    check_idle("bp.after");
    tick();

    // Asynchronous reset after beat 2 of 0x5555 is accepted
    send(16'h5555);
    for (int i = 0; i < 3; i++) begin
      check_beat($sformatf("rs.b%0d", i), 1'b0, 2 * i, i, 1'b0, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("rs.valid",  32'(out_valid),  32'd0);
    check("rs.ready",  32'(in_ready),   32'd1);
    check("rs.idx",    32'(out_idx),    32'd0);
    check("rs.onehot", 32'(out_onehot), 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    check_idle("rs.release");
    send(16'h0001);
    check_beat("rs.x0001", 1'b0, 0, 0, 1'b1, 1'b0);
    tick();
    check_idle("rs.x0001.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
